// File: rtl/apb_pkg.sv
// Shared types for the APB command-to-transfer requester: FSM encoding,
// the word-alignment mask and the response record.
package apb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } apb_state_e;

  localparam logic [1:0] APB_ALIGN_MASK = 2'b11;

  // Response record width; the requester's DATA_W must not exceed it.
  localparam int APB_RSP_DATA_W = 32;

  typedef struct packed {
    logic [APB_RSP_DATA_W-1:0] rdata;
    logic                      err;
  } apb_rsp_t;

endpackage

// File: rtl/apb_timeout_ctr.sv
// Access-phase wait counter: cleared in SETUP, counts stalled ACCESS cycles,
// flags the stalled cycle that brings the count up to LIMIT.
module apb_timeout_ctr #(
  parameter int LIMIT = 16
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic inc_i,
  output logic expired_o
);

  localparam int CW = $clog2(LIMIT + 1);

  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) begin
      cnt_q <= '0;
    end else if (inc_i && (cnt_q != CW'(LIMIT))) begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

  assign expired_o = inc_i && (cnt_q == CW'(LIMIT - 1));

endmodule

// File: rtl/apb_master.sv
// Command-driven APB3 requester: one transfer outstanding, registered outputs.
// Optional access-phase timeout abort is enabled with the APB_TIMEOUT_EN macro.
module apb_master
  import apb_pkg::*;
#(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              CMD_VALID,
  output logic              CMD_READY,
  input  logic              CMD_WRITE,
  input  logic [ADDR_W-1:0] CMD_ADDR,
  input  logic [DATA_W-1:0] CMD_WDATA,
  output logic              RSP_VALID,
  input  logic              RSP_READY,
  output logic [DATA_W-1:0] RSP_RDATA,
  output logic              RSP_ERR,
  output logic [ADDR_W-1:0] PADDR,
  output logic              PSEL,
  output logic              PENABLE,
  output logic              PWRITE,
  output logic [DATA_W-1:0] PWDATA,
  input  logic              PREADY,
  input  logic              PSLVERR,
  input  logic [DATA_W-1:0] PRDATA
);

  if (DATA_W > APB_RSP_DATA_W || ADDR_W < 2 || TIMEOUT_CYCLES < 1) begin : g_param_check
    $error("apb_master: unsupported parameterisation");
  end

  apb_state_e        state_q;
  logic              cmd_ready_q;
  logic              rsp_valid_q;
  apb_rsp_t          rsp_q;
  logic [ADDR_W-1:0] paddr_q;
  logic [DATA_W-1:0] pwdata_q;
  logic              psel_q;
  logic              penable_q;
  logic              pwrite_q;
  logic              timeout_hit;

`ifdef APB_TIMEOUT_EN
  apb_timeout_ctr #(
    .LIMIT(TIMEOUT_CYCLES)
  ) u_timeout_ctr (
    .clk_i    (CLK),
    .rst_i    (RESET),
    .clr_i    (state_q == ST_SETUP),
    .inc_i    ((state_q == ST_ACCESS) && !PREADY),
    .expired_o(timeout_hit)
  );
`else
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q     <= ST_IDLE;
      cmd_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_q       <= '0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (CMD_VALID) begin
            cmd_ready_q <= 1'b0;
            // Misaligned commands never reach the bus; they fail immediately.
            if ((CMD_ADDR[1:0] & APB_ALIGN_MASK) != 2'b00) begin
              rsp_q.rdata <= '0;
              rsp_q.err   <= 1'b1;
              rsp_valid_q <= 1'b1;
              state_q     <= ST_RESP;
            end else begin
              paddr_q  <= CMD_ADDR;
              pwdata_q <= CMD_WDATA;
              pwrite_q <= CMD_WRITE;
              psel_q   <= 1'b1;
              state_q  <= ST_SETUP;
            end
          end
        end
        ST_SETUP: begin
          penable_q <= 1'b1;
          state_q   <= ST_ACCESS;
        end
        ST_ACCESS: begin
          // PREADY is checked first so a completion on the limit cycle wins.
          if (PREADY) begin
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            rsp_q.rdata <= (pwrite_q || PSLVERR) ? '0 : APB_RSP_DATA_W'(PRDATA);
            rsp_q.err   <= PSLVERR;
            rsp_valid_q <= 1'b1;
            state_q     <= ST_RESP;
          end else if (timeout_hit) begin
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            rsp_q.rdata <= '0;
            rsp_q.err   <= 1'b1;
            rsp_valid_q <= 1'b1;
            state_q     <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (RSP_READY) begin
            rsp_valid_q <= 1'b0;
            cmd_ready_q <= 1'b1;
            state_q     <= ST_IDLE;
          end
        end
        default: begin
          state_q     <= ST_IDLE;
          cmd_ready_q <= 1'b1;
          rsp_valid_q <= 1'b0;
          psel_q      <= 1'b0;
          penable_q   <= 1'b0;
        end
      endcase
    end
  end

  assign CMD_READY = cmd_ready_q;
  assign RSP_VALID = rsp_valid_q;
  assign RSP_RDATA = rsp_q.rdata[DATA_W-1:0];
  assign RSP_ERR   = rsp_q.err;
  assign PADDR     = paddr_q;
  assign PWDATA    = pwdata_q;
  assign PSEL      = psel_q;
  assign PENABLE   = penable_q;
  assign PWRITE    = pwrite_q;

endmodule

// File: tb/tb_apb_master.sv
// Directed + randomized bench for apb_master against a small register-file
// slave and a transaction-level expectation model.
module tb_apb_master;

  localparam int TMO = 16;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic        CMD_VALID = 1'b0;
  logic        CMD_READY;
  logic        CMD_WRITE = 1'b0;
  logic [31:0] CMD_ADDR = '0;
  logic [31:0] CMD_WDATA = '0;
  logic        RSP_VALID;
  logic        RSP_READY = 1'b0;
  logic [31:0] RSP_RDATA;
  logic        RSP_ERR;
  logic [31:0] PADDR;
  logic        PSEL;
  logic        PENABLE;
  logic        PWRITE;
  logic [31:0] PWDATA;
  logic        PREADY = 1'b0;
  logic        PSLVERR = 1'b0;
  logic [31:0] PRDATA = '0;

  int vectors = 0;
  int miscompares = 0;

  // Slave register file (raw storage) and the bench's expected view of it.
  logic [31:0] slv_mem [16];
  logic [31:0] ref_mem [16];
  int          slv_waits = 0;
  bit          slv_stuck = 1'b0;

  apb_master #(
    .ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .CLK(CLK), .RESET(RESET),
    .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY), .CMD_WRITE(CMD_WRITE),
    .CMD_ADDR(CMD_ADDR), .CMD_WDATA(CMD_WDATA),
    .RSP_VALID(RSP_VALID), .RSP_READY(RSP_READY), .RSP_RDATA(RSP_RDATA), .RSP_ERR(RSP_ERR),
    .PADDR(PADDR), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PWDATA(PWDATA),
    .PREADY(PREADY), .PSLVERR(PSLVERR), .PRDATA(PRDATA)
  );

  initial forever #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // Slave: wait states, PSLVERR at 0x08, bit 0 of 0x04 reads back as 0.
  initial forever begin
    int acc_n;
    logic [3:0] idx;
    @(negedge CLK);
    if (PSEL && PENABLE) acc_n++; else acc_n = 0;
    idx     = PADDR[5:2];
    PREADY  = PSEL && PENABLE && (acc_n > slv_waits) && !slv_stuck;
    PSLVERR = PREADY && (PADDR == 32'h8);
    PRDATA  = (idx == 4'd1) ? {slv_mem[idx][31:1], 1'b0} : slv_mem[idx];
    if (PREADY && PWRITE && !PSLVERR) slv_mem[idx] = PWDATA;
  end

  // Bus protocol monitor.
  initial forever begin
    logic [31:0] paddr_prev, pwdata_prev;
    logic        psel_prev, pwrite_prev, rst_prev;
    @(negedge CLK);
    if (PENABLE) check("penable_without_psel", 64'(PSEL), 64'd1);
    if (rst_prev && RESET) check("psel_in_reset", 64'({PSEL, PENABLE}), 64'd0);
    if (psel_prev && PSEL) begin
      check("paddr_stable", 64'(PADDR), 64'(paddr_prev));
      check("pwdata_stable", 64'(PWDATA), 64'(pwdata_prev));
      check("pwrite_stable", 64'(PWRITE), 64'(pwrite_prev));
    end
    psel_prev = PSEL; paddr_prev = PADDR; pwdata_prev = PWDATA;
    pwrite_prev = PWRITE; rst_prev = RESET;
  end

  // One command/response transaction; latencies counted in edges after acceptance.
  task automatic txn(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                     input int waits, input int rdelay, input bit hold_hi, input bit stuck);
    logic [31:0] exp_rd;
    logic        exp_err;
    int          exp_psel, exp_pen, exp_rsp;
    int          psel_k, pen_k, rsp_k, n;
    bit          mis;
    mis = (addr[1:0] != 2'b00);
    exp_rd = '0;
    exp_err = 1'b0;
    if (mis || stuck || addr == 32'h8) exp_err = 1'b1;
    else if (wr) ref_mem[addr[5:2]] = (addr == 32'h4) ? (wdata & 32'hFFFF_FFFE) : wdata;
    else exp_rd = ref_mem[addr[5:2]];
    exp_psel = mis ? -1 : 0;
    exp_pen  = mis ? -1 : 1;
    exp_rsp  = mis ? 0 : (stuck ? 1 + TMO : 2 + waits);

    n = 0;
    while (!CMD_READY && n < 50) begin step(); n++; end
    check("cmd_ready_idle", 64'(CMD_READY), 64'd1);
    slv_waits = waits;
    slv_stuck = stuck;
    RSP_READY = hold_hi;
    CMD_VALID = 1'b1; CMD_WRITE = wr; CMD_ADDR = addr; CMD_WDATA = wdata;
    step();
    // Keep presenting junk commands; they must be ignored while busy.
    CMD_WRITE = 1'($urandom); CMD_ADDR = $urandom; CMD_WDATA = $urandom;
    check("cmd_ready_busy", 64'(CMD_READY), 64'd0);
    psel_k = -1; pen_k = -1; rsp_k = -1;
    for (int k = 0; k < 200; k++) begin
      if (PSEL && psel_k < 0) begin
        psel_k = k;
        check("paddr", 64'(PADDR), 64'(addr));
        check("pwrite", 64'(PWRITE), 64'(wr));
        if (wr) check("pwdata", 64'(PWDATA), 64'(wdata));
      end
      if (PENABLE && pen_k < 0) pen_k = k;
      if (RSP_VALID) begin rsp_k = k; break; end
      step();
    end
    CMD_VALID = 1'b0;
    check("psel_latency", 64'(psel_k), 64'(exp_psel));
    check("penable_latency", 64'(pen_k), 64'(exp_pen));
    check("rsp_latency", 64'(rsp_k), 64'(exp_rsp));
    check("rsp_rdata", 64'(RSP_RDATA), 64'(exp_rd));
    check("rsp_err", 64'(RSP_ERR), 64'(exp_err));
    check("bus_idle_in_resp", 64'({PSEL, PENABLE}), 64'd0);
    if (!hold_hi) begin
      for (int r = 0; r < rdelay; r++) begin
        step();
        check("rsp_hold_valid", 64'(RSP_VALID), 64'd1);
        check("rsp_hold_rdata", 64'(RSP_RDATA), 64'(exp_rd));
        check("rsp_hold_err", 64'(RSP_ERR), 64'(exp_err));
        check("rsp_hold_cmd_ready", 64'(CMD_READY), 64'd0);
      end
      RSP_READY = 1'b1;
    end
    step();
    RSP_READY = 1'b0;
    check("rsp_done_valid", 64'(RSP_VALID), 64'd0);
    check("rsp_done_cmd_ready", 64'(CMD_READY), 64'd1);
    slv_stuck = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 16; i++) begin
      slv_mem[i] = 32'h1111_1111 * i;
      ref_mem[i] = 32'h1111_1111 * i;
    end
    slv_mem[0] = 32'h5A5A_5A5A; ref_mem[0] = 32'h5A5A_5A5A;
    slv_mem[3] = 32'h0000_0123; ref_mem[3] = 32'h0000_0123;

    RESET = 1'b1;
    step(); step();
    check("rst_apb", 64'({PSEL, PENABLE, PWRITE}), 64'd0);
    check("rst_paddr", 64'(PADDR), 64'd0);
    check("rst_pwdata", 64'(PWDATA), 64'd0);
    check("rst_rsp", 64'({RSP_VALID, RSP_ERR}), 64'd0);
    check("rst_rdata", 64'(RSP_RDATA), 64'd0);
    RESET = 1'b0;
    step();
    check("cmd_ready_after_reset", 64'(CMD_READY), 64'd1);

    txn(1'b0, 32'h00, 32'h0, 0, 0, 1'b0, 1'b0);
    txn(1'b1, 32'h04, 32'h0000_A003, 0, 0, 1'b0, 1'b0);
    txn(1'b0, 32'h04, 32'h0, 0, 0, 1'b0, 1'b0);
    txn(1'b0, 32'h0C, 32'h0, 5, 0, 1'b0, 1'b0);
    txn(1'b0, 32'h06, 32'h0, 0, 0, 1'b0, 1'b0);
    txn(1'b0, 32'h08, 32'h0, 0, 0, 1'b0, 1'b0);
    txn(1'b0, 32'h10, 32'h0, 1, 4, 1'b0, 1'b0);
    txn(1'b1, 32'h14, 32'hCAFE_F00D, 0, 0, 1'b1, 1'b0);
    txn(1'b0, 32'h14, 32'h0, 0, 0, 1'b1, 1'b0);
    txn(1'b0, 32'h18, 32'h0, TMO - 1, 0, 1'b0, 1'b0);

    // Reset pulsed mid-ACCESS with a stalled slave.
    slv_stuck = 1'b1;
    CMD_VALID = 1'b1; CMD_WRITE = 1'b0; CMD_ADDR = 32'h1C;
    step();
    CMD_VALID = 1'b0;
    step(); step(); step();
    check("mid_access_penable", 64'({PSEL, PENABLE}), 64'd3);
    RESET = 1'b1;
    step();
    check("reset_drops_bus", 64'({PSEL, PENABLE}), 64'd0);
    check("reset_no_rsp", 64'(RSP_VALID), 64'd0);
    step();
    RESET = 1'b0;
    slv_stuck = 1'b0;
    step();
    check("post_reset_ready", 64'(CMD_READY), 64'd1);
    check("post_reset_idle", 64'({PSEL, PENABLE, RSP_VALID}), 64'd0);

`ifdef APB_TIMEOUT_EN
    txn(1'b0, 32'h20, 32'h0, 0, 0, 1'b0, 1'b1);
`endif

    for (int t = 0; t < 40; t++) begin
      logic [31:0] a;
      a = {26'd0, 4'($urandom), 2'b00};
      if ($urandom_range(0, 7) == 0) a[1:0] = 2'($urandom_range(1, 3));
      txn(1'($urandom), a, $urandom, $urandom_range(0, 3), $urandom_range(0, 3),
          1'($urandom), 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/apb_master.md
Name: apb_master

Overview:
- Command-driven APB requester. It converts a simple valid/ready command stream into APB3 setup/access transfers and returns read data or error on a valid/ready response stream.
- It sits between a host-side controller or test sequencer and the GCD accelerator's APB register file.
- It is used to program CTRL, poll STATUS, and read CYCLE_COUNT and the DEBUG registers.

Parameters:
- ADDR_W, 32, width of CMD_ADDR and PADDR.
- DATA_W, 32, width of write data, read data and the PWDATA/PRDATA buses.
- TIMEOUT_CYCLES, 16, number of access-phase cycles allowed before a timeout abort (used only with APB_TIMEOUT_EN).

Ports:
- CLK  in  1  clock; all logic on the rising edge.
- RESET  in  1  synchronous, active-high reset.
- CMD_VALID  in  1  command present.
- CMD_READY  out  1  command accepted when high together with CMD_VALID.
- CMD_WRITE  in  1  1 = write, 0 = read.
- CMD_ADDR  in  ADDR_W  byte address.
- CMD_WDATA  in  DATA_W  write data.
- RSP_VALID  out  1  response present.
- RSP_READY  in  1  response consumed when high together with RSP_VALID.
- RSP_RDATA  out  DATA_W  read data; 0 for writes and errors.
- RSP_ERR  out  1  PSLVERR, misalignment or timeout.
- PADDR  out  ADDR_W  APB address.
- PSEL  out  1  APB select.
- PENABLE  out  1  APB enable.
- PWRITE  out  1  APB direction.
- PWDATA  out  DATA_W  APB write data.
- PREADY  in  1  APB ready.
- PSLVERR  in  1  APB error.
- PRDATA  in  DATA_W  APB read data.

Interface fixed decision: one clock; reset is synchronous and active-high. Ports are CLK and RESET.

Behaviour:
- All outputs are registered.
- Reset values:
  - state IDLE.
  - PSEL, PENABLE, PWRITE = 0.
  - PADDR, PWDATA = 0.
  - RSP_VALID, RSP_ERR = 0; RSP_RDATA = 0.
  - CMD_READY = 1 in the first cycle after RESET deasserts.
- CMD_READY is high only in IDLE.
- FSM IDLE:
  - On CMD_VALID with an aligned address (CMD_ADDR[1:0] == 0): latch address, data and direction; go to SETUP.
  - On CMD_VALID with a misaligned address: go directly to RESP with RSP_ERR = 1 and RSP_RDATA = 0. No PSEL is driven.
- FSM SETUP (exactly one cycle): PSEL = 1, PENABLE = 0, PADDR/PWRITE/PWDATA valid. Next state ACCESS.
- FSM ACCESS: PSEL = 1, PENABLE = 1, all other APB outputs held stable.
  - When PREADY = 1: capture PRDATA (reads only; forced to 0 for writes) and PSLVERR.
  - In the same edge, deassert PSEL and PENABLE and go to RESP.
  - When PREADY = 0: stay in ACCESS.
- FSM RESP: RSP_VALID = 1; RSP_RDATA and RSP_ERR held stable until RSP_READY.
  - On the handshake: RSP_VALID = 0 and go to IDLE.
- Latency with a zero-wait-state slave:
  - Command accepted at edge 0.
  - PSEL high after edge 0, PENABLE high after edge 1.
  - RSP_VALID high after edge 2.
  - Next CMD_READY after the response handshake edge.
- Ordering: exactly one transfer is outstanding at a time, so responses are in command order.
- Boundary cases:
  - PADDR and PWDATA never change while PSEL = 1.
  - PSEL and PENABLE never go high while RESET = 1.
  - PENABLE is never high without PSEL.
  - RESET asserted in any state, including mid-ACCESS, returns to IDLE the next edge and drops PSEL/PENABLE. The pending response is discarded.
  - RSP_READY held high permanently: RESP lasts exactly one cycle.
  - CMD_VALID while not in IDLE: ignored; no latching.

Optional Feature:
- Macro APB_TIMEOUT_EN.
- Defined:
  - A counter clears on SETUP and increments each ACCESS cycle with PREADY = 0.
  - When the count reaches TIMEOUT_CYCLES, abort: drop PSEL/PENABLE, go to RESP with RSP_ERR = 1 and RSP_RDATA = 0.
  - PREADY = 1 in the same cycle the limit is reached wins, giving a normal completion.
- Not defined: there is no counter, and ACCESS waits indefinitely for PREADY.

Decomposition:
- Shared package apb_pkg holds:
  - the state encoding enum (IDLE, SETUP, ACCESS, RESP);
  - the APB_ALIGN_MASK constant (2'b11);
  - the response struct {rdata, err}.
- One sub-module: apb_timeout_ctr (counter plus expiry compare), instantiated only under APB_TIMEOUT_EN.

Test Plan:
- Read 0x00 from a zero-wait register-file model:
  - PSEL rises 1 cycle after acceptance, PENABLE 1 cycle later.
  - RSP_VALID 3 cycles after acceptance, RSP_RDATA = 0x5A5A5A5A, RSP_ERR = 0.
- Write 0x04 data 0x0000A003, then read 0x04:
  - PWRITE = 1 and PWDATA = 0x0000A003 stable through SETUP and ACCESS.
  - The write response has RSP_RDATA = 0.
  - The read returns 0x0000A002 (the START bit is not stored).
- Slave holds PREADY = 0 for 5 ACCESS cycles on a read of 0x0C returning 0x123:
  - ACCESS lasts 6 cycles with PADDR stable.
  - RSP_RDATA = 0x00000123.
- Misaligned read 0x06: no PSEL ever, RSP_VALID with RSP_ERR = 1 after 1 cycle. PSLVERR = 1 on a read of 0x08: RSP_ERR = 1.
- RSP_READY held low for 4 cycles:
  - RSP_VALID and RSP_RDATA stay stable and CMD_READY stays 0.
  - The handshake then returns to IDLE.
- RESET pulsed during ACCESS: PSEL/PENABLE = 0 the next cycle, no RSP_VALID. With APB_TIMEOUT_EN, PREADY stuck at 0: abort after 16 cycles with RSP_ERR = 1.
